// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one busy-stalled memory port between fetch and data requesters
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr                  fetch request, held until if_done
//   if_rdata/if_done/if_err         fetch response (done is a one-cycle pulse, err marks a watchdog abort)
//   d_req/d_we/d_addr/d_wdata       load/store request, held until d_done
//   d_rdata/d_done/d_err            load/store response
//   mem_req/mem_we/mem_addr/mem_wdata  memory command, held stable while the memory stalls
//   mem_rdata/mem_busy              memory response; completion is the first cycle with mem_busy=0
//
// All outputs come straight from flops; no input reaches an output combinationally.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy
);

    // A TIMEOUT of 0 disables the watchdog; keep the counter at least one bit wide so it stays legal.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    logic [1:0]        state_q,     state_d;
    logic              last_gnt_q,  last_gnt_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_done_q,   if_done_d;
    logic              d_done_q,    d_done_d;
    logic              if_err_q,    if_err_d;
    logic              d_err_q,     d_err_d;

    logic              grant_if;

    // IF wins when it is the only requester or when D held the previous grant.
    assign grant_if = if_req && (!d_req || (last_gnt_q == PORT_D));

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        // Done/err are raised only on the BUSY->RESP edge, so they fall by default one cycle later.
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_err_d    = 1'b0;
        d_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_if) begin
                    last_gnt_d  = PORT_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end else if (d_req) begin
                    last_gnt_d  = PORT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                    state_d     = ST_BUSY;
                end
            end

            // last_gnt_q names the current winner for the whole transaction.
            ST_BUSY: begin
                if (!mem_busy) begin
                    if (!mem_we_q) begin
                        if (last_gnt_q == PORT_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if_done_d   = (last_gnt_q == PORT_IF);
                    d_done_d    = (last_gnt_q == PORT_D);
                    state_d     = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    if (last_gnt_q == PORT_IF) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if_done_d   = (last_gnt_q == PORT_IF);
                    d_done_d    = (last_gnt_q == PORT_D);
                    if_err_d    = (last_gnt_q == PORT_IF);
                    d_err_d     = (last_gnt_q == PORT_D);
                    state_d     = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= PORT_D;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_err_q    <= if_err_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_err    = if_err_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    int n_assert = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_busy (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_busy  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_mem_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we",    {31'b0, mem_we},  32'd0);
        chk("rst_mem_addr",  mem_addr,         32'd0);
        chk("rst_mem_wdata", mem_wdata,        32'd0);
        chk("rst_if_done",   {31'b0, if_done}, 32'd0);
        chk("rst_d_done",    {31'b0, d_done},  32'd0);
        chk("rst_if_err",    {31'b0, if_err},  32'd0);
        chk("rst_d_err",     {31'b0, d_err},   32'd0);
        chk("rst_if_rdata",  if_rdata,         32'd0);
        chk("rst_d_rdata",   d_rdata,          32'd0);

        // Test 1: single fetch, no stall
        rst_n     = 1'b1;
        if_req    = 1'b1;
        if_addr   = 32'h10;
        mem_busy  = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        tick();
        chk("t1_c1_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t1_c1_mem_addr", mem_addr,         32'h10);
        chk("t1_c1_mem_we",   {31'b0, mem_we},  32'd0);
        tick();
        chk("t1_c2_if_done",  {31'b0, if_done}, 32'd1);
        chk("t1_c2_if_rdata", if_rdata,         32'hDEADBEEF);
        chk("t1_c2_if_err",   {31'b0, if_err},  32'd0);
        chk("t1_c2_mem_addr", mem_addr,         32'd0);
        chk("t1_c2_mem_req",  {31'b0, mem_req}, 32'd0);
        chk("t1_c2_d_done",   {31'b0, d_done},  32'd0);
        if_req = 1'b0;
        tick();
        chk("t1_c3_if_done",  {31'b0, if_done}, 32'd0);
        chk("t1_c3_mem_req",  {31'b0, mem_req}, 32'd0);

        // Test 2: both ports held from reset -> IF, D, IF, D
        rst_n     = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h20;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h40;
        mem_rdata = 32'h11110000;
        tick();
        chk("t2_rst_if_rdata", if_rdata, 32'd0);
        rst_n = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if ((c % 3) == 1) begin
                chk("t2_mem_req",  {31'b0, mem_req}, 32'd1);
                chk("t2_mem_addr", mem_addr, (((c / 3) % 2) == 0) ? 32'h20 : 32'h40);
            end else begin
                chk("t2_mem_idle", {31'b0, mem_req}, 32'd0);
            end
            chk("t2_if_done", {31'b0, if_done},
                {31'b0, ((c % 3) == 2) && (((c / 3) % 2) == 0)});
            chk("t2_d_done", {31'b0, d_done},
                {31'b0, ((c % 3) == 2) && (((c / 3) % 2) == 1)});
        end
        chk("t2_if_rdata", if_rdata, 32'h11110000);
        chk("t2_d_rdata",  d_rdata,  32'h11110000);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        chk("t2_end_mem_req", {31'b0, mem_req}, 32'd0);

        // Test 3: data write stalled 4 cycles
        d_req     = 1'b1;
        d_we      = 1'b1;
        d_addr    = 32'h80;
        d_wdata   = 32'h1234;
        mem_busy  = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("t3_mem_req",   {31'b0, mem_req}, 32'd1);
            chk("t3_mem_we",    {31'b0, mem_we},  32'd1);
            chk("t3_mem_addr",  mem_addr,         32'h80);
            chk("t3_mem_wdata", mem_wdata,        32'h1234);
            chk("t3_d_done",    {31'b0, d_done},  32'd0);
        end
        mem_busy = 1'b0;
        tick();
        chk("t3_c6_d_done",    {31'b0, d_done},  32'd1);
        chk("t3_c6_d_err",     {31'b0, d_err},   32'd0);
        chk("t3_c6_d_rdata",   d_rdata,          32'h11110000);
        chk("t3_c6_mem_req",   {31'b0, mem_req}, 32'd0);
        chk("t3_c6_mem_we",    {31'b0, mem_we},  32'd0);
        chk("t3_c6_mem_wdata", mem_wdata,        32'd0);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        chk("t3_c7_d_done", {31'b0, d_done}, 32'd0);

        // Test 4: watchdog abort on IF, pending D served afterwards
        if_req    = 1'b1;
        if_addr   = 32'h30;
        d_req     = 1'b1;
        d_addr    = 32'h44;
        mem_busy  = 1'b1;
        mem_rdata = 32'h5555AAAA;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("t4_mem_req",  {31'b0, mem_req}, 32'd1);
            chk("t4_mem_addr", mem_addr,         32'h30);
            chk("t4_if_done",  {31'b0, if_done}, 32'd0);
        end
        tick();
        chk("t4_c9_mem_req",  {31'b0, mem_req}, 32'd0);
        chk("t4_c9_mem_addr", mem_addr,         32'd0);
        chk("t4_c9_if_done",  {31'b0, if_done}, 32'd1);
        chk("t4_c9_if_err",   {31'b0, if_err},  32'd1);
        chk("t4_c9_if_rdata", if_rdata,         32'd0);
        chk("t4_c9_d_done",   {31'b0, d_done},  32'd0);
        chk("t4_c9_d_err",    {31'b0, d_err},   32'd0);
        if_req   = 1'b0;
        mem_busy = 1'b0;
        tick();
        chk("t4_c10_if_done", {31'b0, if_done}, 32'd0);
        chk("t4_c10_if_err",  {31'b0, if_err},  32'd0);
        chk("t4_c10_mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("t4_c11_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t4_c11_mem_addr", mem_addr,         32'h44);
        chk("t4_c11_mem_we",   {31'b0, mem_we},  32'd0);
        tick();
        chk("t4_c12_d_done",  {31'b0, d_done}, 32'd1);
        chk("t4_c12_d_err",   {31'b0, d_err},  32'd0);
        chk("t4_c12_d_rdata", d_rdata,         32'h5555AAAA);
        d_req = 1'b0;
        tick();

        // Test 5: reset during a stalled transaction
        if_req   = 1'b1;
        d_req    = 1'b1;
        mem_busy = 1'b1;
        tick();
        chk("t5_c1_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t5_c1_mem_addr", mem_addr,         32'h30);
        tick();
        chk("t5_c2_mem_req",  {31'b0, mem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_c3_mem_req",  {31'b0, mem_req}, 32'd0);
        chk("t5_c3_mem_addr", mem_addr,         32'd0);
        chk("t5_c3_if_done",  {31'b0, if_done}, 32'd0);
        chk("t5_c3_d_done",   {31'b0, d_done},  32'd0);
        chk("t5_c3_d_rdata",  d_rdata,          32'd0);
        rst_n     = 1'b1;
        mem_busy  = 1'b0;
        mem_rdata = 32'h77770000;
        tick();
        chk("t5_c4_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t5_c4_mem_addr", mem_addr,         32'h30);
        tick();
        chk("t5_c5_if_done",  {31'b0, if_done}, 32'd1);
        chk("t5_c5_d_done",   {31'b0, d_done},  32'd0);
        chk("t5_c5_if_rdata", if_rdata,         32'h77770000);
        tick();
        chk("t5_c6_if_done",  {31'b0, if_done}, 32'd0);
        chk("t5_c6_mem_req",  {31'b0, mem_req}, 32'd0);
        tick();
        chk("t5_c7_mem_addr", mem_addr,         32'h44);
        tick();
        chk("t5_c8_d_done",   {31'b0, d_done},  32'd1);
        chk("t5_c8_d_rdata",  d_rdata,          32'h77770000);
        d_req = 1'b0;

        // Test 6: back-to-back IF, then D wins the next tie
        tick();
        chk("t6_c9_d_done",   {31'b0, d_done},  32'd0);
        chk("t6_c9_mem_req",  {31'b0, mem_req}, 32'd0);
        tick();
        chk("t6_c10_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t6_c10_mem_addr", mem_addr,         32'h30);
        tick();
        chk("t6_c11_if_done", {31'b0, if_done}, 32'd1);
        tick();
        chk("t6_c12_if_done", {31'b0, if_done}, 32'd0);
        chk("t6_c12_mem_req", {31'b0, mem_req}, 32'd0);
        tick();
        chk("t6_c13_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t6_c13_mem_addr", mem_addr,         32'h30);
        d_req = 1'b1;
        tick();
        chk("t6_c14_if_done", {31'b0, if_done}, 32'd1);
        chk("t6_c14_d_done",  {31'b0, d_done},  32'd0);
        tick();
        tick();
        chk("t6_c16_mem_req",  {31'b0, mem_req}, 32'd1);
        chk("t6_c16_mem_addr", mem_addr,         32'h44);
        tick();
        chk("t6_c17_d_done",  {31'b0, d_done},  32'd1);
        chk("t6_c17_if_done", {31'b0, if_done}, 32'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        chk("t6_end_mem_req", {31'b0, mem_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, busy-stalled memory between two requesters: instruction fetch (port IF) and load/store data (port D) of the multi-cycle core.
- Arbitration is round-robin.
- Each transaction is driven to the memory, held until the memory completes it, and then returned to the winner as a one-cycle done pulse.
- A programmable watchdog aborts transactions the memory never completes.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max consecutive mem_busy=1 cycles before abort; 0 disables the watchdog

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held with if_addr until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word; valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  qualifies if_done; watchdog abort
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_done
- d_we  in  1  1=write, 0=read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid while d_done=1 and d_we=0
- d_done  out  1  one-cycle completion pulse
- d_err  out  1  qualifies d_done; watchdog abort
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address; 0 when mem_req=0
- mem_wdata  out  DATA_W  memory write data; 0 when mem_req=0
- mem_rdata  in  DATA_W  memory read data; valid in a cycle with mem_req=1, mem_busy=0
- mem_busy  in  1  memory stall; a transaction completes in the first cycle with mem_req=1 and mem_busy=0

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, last_gnt=D (so IF wins the first tie), wait counter=0.
  - mem_req, mem_we, mem_addr, mem_wdata, if_done, d_done, if_err, d_err, if_rdata, d_rdata all 0.
  - Reset mid-transaction abandons the transaction silently: no done pulse, and mem_req is 0 in the cycle after the reset edge.
- All outputs are registered; there are no combinational input-to-output paths.
- State IDLE:
  - Sample if_req/d_req.
  - Only one request set: grant it.
  - Both set: grant the port that is not last_gnt.
  - On a grant: latch the winner's we/addr/wdata into mem_we/mem_addr/mem_wdata (IF always reads, mem_we=0), set mem_req=1, update last_gnt, clear the wait counter, go to BUSY.
  - No request: stay in IDLE.
- State BUSY (mem_* held stable):
  - mem_busy=0: completion.
    - Read: winner's rdata register <= mem_rdata.
    - Write: the rdata register is unchanged.
    - Drive mem_req=0 and clear mem_addr/mem_wdata/mem_we, then go to RESP with err=0.
  - mem_busy=1 and TIMEOUT≠0 and counter=TIMEOUT-1: abort.
    - mem_req=0, winner's rdata register <= 0, go to RESP with err=1.
  - Otherwise: counter+1 (saturating width clog2(TIMEOUT+1)), stay in BUSY.
- State RESP:
  - Winner's done=1 for exactly one cycle; err=1 only if the transaction aborted.
  - The other port's done/err stay 0.
  - Next state is IDLE.
- Latency and occupancy:
  - Request in cycle 0 (IDLE), mem_req in cycle 1, done in cycle N+2, where N is the number of mem_busy=1 cycles.
  - Minimum occupancy is 3 cycles per transaction.
- Requester rule:
  - The requester samples done at the edge ending the RESP cycle.
  - req still high in the following cycle means a new request.
  - req or its fields changing before done is a protocol violation; the latched copy is used regardless.
- Fairness:
  - Under continuous requests on both ports, grants strictly alternate.
  - Worst-case wait for a port is one other transaction.
- Simultaneous events: a request arriving while in BUSY or RESP waits for IDLE; it is never lost because requests are level-held.
- mem_rdata is ignored outside completion cycles.

Test Plan:
1. Reset, then if_req=1, if_addr=0x10, mem_busy=0, mem_rdata=0xDEADBEEF -> mem_req=1, mem_addr=0x10 in cycle 1; if_done=1, if_rdata=0xDEADBEEF, if_err=0 in cycle 2; mem_addr=0 in cycle 2.
2. if_req and d_req (read 0x40) both held from reset -> grant order IF, D, IF, D (tie resolution, then alternation); transactions start at cycles 0, 3, 6, 9; done pulses never overlap.
3. d_req write, d_addr=0x80, d_wdata=0x1234, mem_busy=1 for 4 cycles then 0 -> mem_we=1 and mem_addr/mem_wdata stable for 5 cycles; d_done in cycle 6; d_rdata unchanged from its prior value.
4. TIMEOUT=8, if_req=1, mem_busy stuck at 1 -> mem_req high for 8 cycles, then low; if_done=1, if_err=1, if_rdata=0 in cycle 9; a pending d_req is granted next.
5. rst_n=0 for one cycle during BUSY with mem_busy=1 -> mem_req=0 next cycle; no done pulse on either port; state is IDLE, so a held request restarts with the IF-first tie rule.
6. Back-to-back IF requests (if_req kept high after if_done) with d_req idle -> IF granted every 3 cycles; last_gnt=IF, so when d_req asserts while in BUSY, D wins the next tie.
